// File: rtl/regfile_sb.sv
// Parametrised register file with synchronous reset, optional hardwired r0,
// write-to-read bypass and a per-register pending scoreboard with live count.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        writereg,
  input  logic [DATA_W-1:0]        writedata,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg,
  output logic [ADDR_W:0]          busy_count
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regf [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic              wr_en;
  logic              iss_en;
  logic              cnt_inc;
  logic              cnt_dec;

  always_comb begin
    wr_en  = RegWrite    && !((ZERO_REG != 0) && (writereg  == '0));
    iss_en = issue_valid && !((ZERO_REG != 0) && (issue_reg == '0));
    // A same-register issue+write keeps the bit set, so it neither adds nor removes.
    cnt_inc = iss_en && !pending[issue_reg];
    cnt_dec = wr_en && pending[writereg] && !(iss_en && (issue_reg == writereg));
    pending_nxt = pending;
    if (wr_en)  pending_nxt[writereg]  = 1'b0;
    if (iss_en) pending_nxt[issue_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regf[i] <= '0;
      pending    <= '0;
      busy_count <= '0;
    end else begin
      if (wr_en) regf[writereg] <= writedata;
      pending <= pending_nxt;
      case ({cnt_inc, cnt_dec})
        2'b10:   busy_count <= busy_count + (ADDR_W+1)'(1);
        2'b01:   busy_count <= busy_count - (ADDR_W+1)'(1);
        default: busy_count <= busy_count;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    logic              is_zero;

    always_comb begin
      ra      = rd_addr[g*ADDR_W +: ADDR_W];
      is_zero = (ZERO_REG != 0) && (ra == '0);
      fwd     = (BYPASS != 0) && wr_en && (writereg == ra);
      rd_data[g*DATA_W +: DATA_W] = '0;
      rd_busy[g]                  = 1'b0;
      if (!is_zero) begin
        rd_data[g*DATA_W +: DATA_W] = fwd ? writedata : regf[ra];
        // Forwarded value hides the pending bit unless a new producer re-issues it.
        rd_busy[g] = pending[ra] && (!fwd || (iss_en && (issue_reg == ra)));
      end
    end
  end

endmodule
